// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures register-file commits from the writeback debug
// bus into a circular FIFO, tagged with a running commit sequence number.
// Status: occupancy, total commits seen, and a sticky overflow flag.
// Optional feature macro: TRACE_WATCH_EN adds a (register, value) watchpoint
// whose first captured match raises watch_hit and self-freezes capture.
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_we,
  input  logic [2:0]                 commit_waddr,
  input  logic [15:0]                commit_wdata,
  input  logic                       freeze,
  input  logic                       clear,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [SEQ_W-1:0]           rd_seq,
  output logic [2:0]                 rd_waddr,
  output logic [15:0]                rd_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [SEQ_W-1:0]           commit_cnt,
  output logic                       overflow
`ifdef TRACE_WATCH_EN
  ,
  input  logic                       watch_en,
  input  logic [2:0]                 watch_addr,
  input  logic [15:0]                watch_data,
  output logic                       watch_hit
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [SEQ_W-1:0] mem_seq  [DEPTH];
  logic [2:0]       mem_addr [DEPTH];
  logic [15:0]      mem_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic self_freeze;
  logic push_req;
  logic push;
  logic pop;
  logic full;

  // Head is first-word fall-through; zeros when empty.
  always_comb begin
    rd_valid = (count != '0);
    rd_seq   = '0;
    rd_waddr = '0;
    rd_wdata = '0;
    if (rd_valid) begin
      rd_seq   = mem_seq[rd_ptr];
      rd_waddr = mem_addr[rd_ptr];
      rd_wdata = mem_data[rd_ptr];
    end
  end

  // Push/pop qualification; clear suppresses both.
  always_comb begin
    full     = (count == CW'(DEPTH));
    pop      = rd_valid && rd_ready && !clear;
    push_req = commit_we && !freeze && !self_freeze && !clear;
    push     = push_req && (!full || pop);
  end

  // Trace storage; contents need no reset because rd_valid masks them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_seq[wr_ptr]  <= commit_cnt;
      mem_addr[wr_ptr] <= commit_waddr;
      mem_data[wr_ptr] <= commit_wdata;
    end
  end

  // Pointers, occupancy, commit counter and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      commit_cnt <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      commit_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (commit_we) commit_cnt <= commit_cnt + SEQ_W'(1);
      if (push_req && !push) overflow <= 1'b1;
    end
  end

`ifdef TRACE_WATCH_EN
  logic watch_match;

  // Watchpoint compare against the incoming commit.
  always_comb begin
    watch_match = watch_en && (commit_waddr == watch_addr) &&
                  (commit_wdata == watch_data);
  end

  // Sticky hit and self-freeze, released only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      watch_hit   <= 1'b0;
      self_freeze <= 1'b0;
    end else if (clear) begin
      watch_hit   <= 1'b0;
      self_freeze <= 1'b0;
    end else if (push && watch_match) begin
      watch_hit   <= 1'b1;
      self_freeze <= 1'b1;
    end
  end
`else
  assign self_freeze = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SEQ_W = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              commit_we;
  logic [2:0]        commit_waddr;
  logic [15:0]       commit_wdata;
  logic              freeze;
  logic              clear;
  logic              rd_valid;
  logic              rd_ready;
  logic [SEQ_W-1:0]  rd_seq;
  logic [2:0]        rd_waddr;
  logic [15:0]       rd_wdata;
  logic [CW-1:0]     count;
  logic [SEQ_W-1:0]  commit_cnt;
  logic              overflow;
`ifdef TRACE_WATCH_EN
  logic              watch_en;
  logic [2:0]        watch_addr;
  logic [15:0]       watch_data;
  logic              watch_hit;
`endif

  int checks = 0;
  int errors = 0;

  commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .freeze(freeze), .clear(clear),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_seq(rd_seq), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .count(count), .commit_cnt(commit_cnt), .overflow(overflow)
`ifdef TRACE_WATCH_EN
    , .watch_en(watch_en), .watch_addr(watch_addr), .watch_data(watch_data),
    .watch_hit(watch_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {seq, addr, data} plus status variables.
  logic [34:0]      mq[$];
  logic [SEQ_W-1:0] m_cnt;
  logic             m_ovf;
  logic             m_hit;
  logic             m_sfrz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_cnt = '0; m_ovf = 1'b0; m_hit = 1'b0; m_sfrz = 1'b0;
    end else if (clear) begin
      mq.delete(); m_cnt = '0; m_ovf = 1'b0; m_hit = 1'b0; m_sfrz = 1'b0;
    end else begin
      bit do_pop, req, acc;
      do_pop = (mq.size() != 0) && rd_ready;
      req    = commit_we && !freeze && !m_sfrz;
      acc    = req && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({m_cnt, commit_waddr, commit_wdata});
`ifdef TRACE_WATCH_EN
        if (watch_en && commit_waddr == watch_addr && commit_wdata == watch_data) begin
          m_hit = 1'b1; m_sfrz = 1'b1;
        end
`endif
      end
      if (req && !acc) m_ovf = 1'b1;
      if (commit_we) m_cnt = m_cnt + SEQ_W'(1);
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [34:0] head;
      head = (mq.size() != 0) ? mq[0] : 35'd0;
      chk("m_rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
      chk("m_rd_head", 64'({rd_seq, rd_waddr, rd_wdata}), 64'(head));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_commit_cnt", 64'(commit_cnt), 64'(m_cnt));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
`ifdef TRACE_WATCH_EN
      chk("m_watch_hit", 64'(watch_hit), 64'(m_hit));
`endif
    end
  end

  // One clock with the given inputs; inputs change just after the edge.
  task automatic cyc(input bit we, input logic [2:0] a, input logic [15:0] d,
                     input bit frz, input bit clr, input bit rdy);
    commit_we = we; commit_waddr = a; commit_wdata = d;
    freeze = frz; clear = clr; rd_ready = rdy;
    @(posedge clk); #1;
    commit_we = 1'b0; freeze = 1'b0; clear = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic idle(); cyc(0, 3'd0, 16'd0, 0, 0, 0); endtask
  task automatic do_clear(); cyc(0, 3'd0, 16'd0, 0, 1, 0); endtask

  task automatic load_use();
    cyc(1, 3'd1, 16'h0005, 0, 0, 0);
    cyc(1, 3'd2, 16'h0000, 0, 0, 0);
    cyc(1, 3'd3, 16'h0005, 0, 0, 0);
    cyc(1, 3'd4, 16'h000A, 0, 0, 0);
  endtask

  logic [34:0] exp_lu [4];

  initial begin
    exp_lu[0] = {16'd0, 3'd1, 16'h0005};
    exp_lu[1] = {16'd1, 3'd2, 16'h0000};
    exp_lu[2] = {16'd2, 3'd3, 16'h0005};
    exp_lu[3] = {16'd3, 3'd4, 16'h000A};
    rst_n = 1'b0; commit_we = 0; commit_waddr = '0; commit_wdata = '0;
    freeze = 0; clear = 0; rd_ready = 0;
`ifdef TRACE_WATCH_EN
    watch_en = 0; watch_addr = '0; watch_data = '0;
`endif
    #12;
    chk("reset_valid", 64'(rd_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_head", 64'({rd_seq, rd_waddr, rd_wdata}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use program, then drain.
    load_use();
    @(negedge clk);
    chk("lu_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lu_head", 64'({rd_seq, rd_waddr, rd_wdata}), 64'(exp_lu[i]));
      cyc(0, 3'd0, 16'd0, 0, 0, 1);
    end
    @(negedge clk);
    chk("lu_cnt", 64'(commit_cnt), 64'd4);
    chk("lu_ovf", 64'(overflow), 64'd0);
    chk("lu_empty", 64'(rd_valid), 64'd0);

    // Overfill: 18 commits into 16 entries.
    do_clear();
    for (int i = 0; i < 18; i++) cyc(1, 3'(i), 16'(i * 3), 0, 0, 0);
    @(negedge clk);
    chk("of_count", 64'(count), 64'd16);
    chk("of_ovf", 64'(overflow), 64'd1);
    chk("of_cnt", 64'(commit_cnt), 64'd18);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("of_seq", 64'(rd_seq), 64'(i));
      cyc(0, 3'd0, 16'd0, 0, 0, 1);
    end

    // Full FIFO with simultaneous push and pop.
    do_clear();
    for (int i = 0; i < 16; i++) cyc(1, 3'd7, 16'(i), 0, 0, 0);
    cyc(1, 3'd6, 16'hBEEF, 0, 0, 1);
    @(negedge clk);
    chk("fp_count", 64'(count), 64'd16);
    chk("fp_ovf", 64'(overflow), 64'd0);
    chk("fp_head", 64'(rd_seq), 64'd1);
    for (int i = 0; i < 16; i++) cyc(0, 3'd0, 16'd0, 0, 0, i < 15);
    @(negedge clk);
    chk("fp_tail", 64'({rd_seq, rd_waddr, rd_wdata}), 64'({16'd16, 3'd6, 16'hBEEF}));
    cyc(0, 3'd0, 16'd0, 0, 0, 1);

    // Freeze on commits 3..5 of 6.
    do_clear();
    for (int i = 0; i < 6; i++) cyc(1, 3'd2, 16'(100 + i), (i >= 2) && (i <= 4), 0, 0);
    @(negedge clk);
    chk("fz_count", 64'(count), 64'd3);
    chk("fz_cnt", 64'(commit_cnt), 64'd6);
    chk("fz_s0", 64'(rd_seq), 64'd0);
    cyc(0, 3'd0, 16'd0, 0, 0, 1);
    chk("fz_s1", 64'(rd_seq), 64'd1);
    cyc(0, 3'd0, 16'd0, 0, 0, 1);
    chk("fz_s2", 64'(rd_seq), 64'd5);

    // Clear coincident with commit and pop at count 5.
    do_clear();
    for (int i = 0; i < 5; i++) cyc(1, 3'd1, 16'(i), 0, 0, 0);
    cyc(1, 3'd5, 16'h1234, 0, 1, 1);
    @(negedge clk);
    chk("cl_count", 64'(count), 64'd0);
    chk("cl_cnt", 64'(commit_cnt), 64'd0);
    chk("cl_valid", 64'(rd_valid), 64'd0);
    chk("cl_ovf", 64'(overflow), 64'd0);

    // Push+pop at count 1: head advances to the new entry.
    cyc(1, 3'd3, 16'h00AA, 0, 0, 0);
    cyc(1, 3'd4, 16'h00BB, 0, 0, 1);
    @(negedge clk);
    chk("pp1_count", 64'(count), 64'd1);
    chk("pp1_head", 64'({rd_seq, rd_waddr, rd_wdata}), 64'({16'd1, 3'd4, 16'h00BB}));
    // Pop on empty ignored.
    cyc(0, 3'd0, 16'd0, 0, 0, 1);
    cyc(0, 3'd0, 16'd0, 0, 0, 1);
    @(negedge clk);
    chk("pe_count", 64'(count), 64'd0);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 3; i++) cyc(1, 3'd2, 16'(i), 0, 0, 0);
    cyc(0, 3'd0, 16'd0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(rd_valid), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_cnt", 64'(commit_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    idle();

`ifdef TRACE_WATCH_EN
    // Watchpoint on R3 = 0x0005 self-freezes capture.
    watch_en = 1'b1; watch_addr = 3'd3; watch_data = 16'h0005;
    load_use();
    @(negedge clk);
    chk("wt_hit", 64'(watch_hit), 64'd1);
    chk("wt_count", 64'(count), 64'd3);
    chk("wt_cnt", 64'(commit_cnt), 64'd4);
    do_clear();
    watch_en = 1'b0;
    cyc(1, 3'd3, 16'h0005, 0, 0, 0);
    @(negedge clk);
    chk("wt_rel_hit", 64'(watch_hit), 64'd0);
    chk("wt_rel_count", 64'(count), 64'd1);
`endif

    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
